// File: rtl/acmv_stim_drv.sv
// acmv_stim_drv: generates a/b/opt for the acmv counter sample so its r3
// counter walks the shortest way to a commanded target. It also keeps a shadow
// copy (mirror) of r3 that can be compared against acmv's x output.
//
//  state  | meaning
//  -------+------------------------------------------------------------
//  S_IDLE | dither mirror around its value, accept a command
//  S_SEEK | step toward target along the shortest path
//  S_DONE | target reached; done pulses this cycle, then back to idle
module acmv_stim_drv #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [W-1:0] cmd_tgt,
  input  logic [1:0]   cmd_sel,
  output logic         a,
  output logic         b,
  output logic [3:0]   opt,
  output logic [W-1:0] mirror,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEEK = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] HALF = {1'b1, {(W-1){1'b0}}};

  state_e         r_state;
  logic           r_started;
  logic           r_a;
  logic           r_b;        // direction register: 0 = up, 1 = down (b == ~dir)
  logic [3:0]     r_opt;
  logic [W-1:0]   r_mirror;
  logic [W-1:0]   r_target;
  logic           r_busy;
  logic           r_done;

  logic [W-1:0]   w_mirror_n;
  logic [W-1:0]   w_diff_cmd;
  logic [W-1:0]   w_diff_tgt;
  logic           w_cmd_down;
  logic           w_tgt_down;
  logic           w_accept;
  logic [3:0]     w_opt_code;

  // r3 steps every cycle, so the mirror does too; direction comes from r_b.
  assign w_mirror_n = r_b ? (r_mirror - ONE) : (r_mirror + ONE);

  // Shortest-path decision against the post-edge mirror; a tie at half range goes up.
  assign w_diff_cmd = cmd_tgt  - w_mirror_n;
  assign w_diff_tgt = r_target - w_mirror_n;
  assign w_cmd_down = (w_diff_cmd > HALF);
  assign w_tgt_down = (w_diff_tgt > HALF);

  // Hold off acceptance until the first edge after reset so cmd_ready reads 0 in reset.
  assign cmd_ready  = (r_state == S_IDLE) && r_started;
  assign w_accept   = cmd_valid && cmd_ready;
  assign w_opt_code = 4'b1000 >> cmd_sel;

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_started <= 1'b0;
      r_a       <= 1'b0;
      r_b       <= 1'b0;
      r_opt     <= 4'b0000;
      r_mirror  <= '0;
      r_target  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_started <= 1'b1;
      r_a       <= 1'b0;
      r_mirror  <= w_mirror_n;
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_state  <= S_SEEK;
            r_target <= cmd_tgt;
            r_opt    <= w_opt_code;
            r_b      <= w_cmd_down;
            r_busy   <= 1'b1;
          end else begin
            r_b <= ~r_b;
          end
        end
        S_SEEK: begin
          if (w_diff_tgt == '0) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_b     <= 1'b0;
          end else begin
            r_b <= w_tgt_down;
          end
        end
        S_DONE: begin
          // First idle cycle steps down, giving the tgt+1, tgt dither.
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_b     <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_b     <= 1'b0;
        end
      endcase
    end
  end

  assign a      = r_a;
  assign b      = r_b;
  assign opt    = r_opt;
  assign mirror = r_mirror;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: tb/tb_acmv_stim_drv.sv
// Directed bench for acmv_stim_drv: the stimulus pushes the expected result of
// each command into a scoreboard, and a monitor checks it when done pulses.
module tb_acmv_stim_drv;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_tgt;
  logic [1:0] cmd_sel;
  logic       a;
  logic       b;
  logic [3:0] opt;
  logic [3:0] mirror;
  logic       busy;
  logic       done;

  typedef struct {
    logic [3:0] tgt;
    logic [3:0] opt;
    int         lat;     // negedges with busy=1, up to and including the done cycle
    logic       b_seek;  // b value expected on every SEEK cycle
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   busy_cnt = 0;

  acmv_stim_drv #(.W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_tgt   (cmd_tgt),
    .cmd_sel   (cmd_sel),
    .a         (a),
    .b         (b),
    .opt       (opt),
    .mirror    (mirror),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic issue(input logic [3:0] tgt, input logic [1:0] sel,
                       input logic [3:0] exp_opt, input int lat, input logic bs);
    exp_t e;
    e.tgt = tgt; e.opt = exp_opt; e.lat = lat; e.b_seek = bs;
    sb.push_back(e);
    cmd_tgt   = tgt;
    cmd_sel   = sel;
    cmd_valid = 1'b1;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (busy && !done) chk("ready_low_while_busy", cmd_ready, 0);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic chk_dither(input logic [3:0] m, input logic bb);
    cyc();
    chk("dither_mirror", mirror, m);
    chk("dither_b", b, bb);
    chk("dither_done", done, 0);
    chk("dither_busy", busy, 0);
    chk("dither_ready", cmd_ready, 1);
  endtask

  // Monitor: checks direction during SEEK and the scoreboard entry on each done.
  always @(negedge clk) begin
    if (rst) begin
      if (busy) busy_cnt++;
      else busy_cnt = 0;
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_mirror", mirror, e.tgt);
          chk("done_opt", opt, e.opt);
          chk("done_latency", busy_cnt, e.lat);
          chk("done_b_up", b, 0);
        end
        busy_cnt = 0;
      end else if (busy && sb.size() > 0) begin
        chk("seek_b", b, sb[0].b_seek);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_tgt = 4'd0; cmd_sel = 2'd0;
    #2;
    chk("rst_a", a, 0);
    chk("rst_b", b, 0);
    chk("rst_opt", opt, 0);
    chk("rst_mirror", mirror, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", cmd_ready, 0);
    #10 rst = 1'b1;

    // Case 1: idle dither 1,0,1,0 with b toggling.
    for (int i = 0; i < 4; i++) begin
      chk_dither((i % 2 == 0) ? 4'd1 : 4'd0, (i % 2 == 0) ? 1'b1 : 1'b0);
      chk("idle_opt", opt, 0);
      chk("idle_a", a, 0);
    end

    // Case 2: mirror=0, tgt=5 sel=2 -> climbs 1..5.
    issue(4'd5, 2'd2, 4'b0010, 5, 1'b0);
    cyc();
    cmd_valid = 1'b0;
    chk("c2_opt_after_accept", opt, 4'b0010);
    chk("c2_mirror_first", mirror, 1);
    chk("c2_busy", busy, 1);
    chk("c2_ready", cmd_ready, 0);
    wait_done();
    chk_dither(4'd6, 1'b1);
    chk_dither(4'd5, 1'b0);
    chk_dither(4'd6, 1'b1);

    // Case 5: tgt=0 from 6 (down), valid held with a new tgt=9 during SEEK.
    issue(4'd0, 2'd1, 4'b0100, 6, 1'b1);
    cyc();
    chk("c5_mirror_first", mirror, 5);
    issue(4'd9, 2'd3, 4'b0001, 8, 1'b1);
    wait_done();
    chk("c5_opt_held", opt, 4'b0100);
    cyc();
    chk("c5_idle_mirror", mirror, 1);
    chk("c5_idle_ready", cmd_ready, 1);
    chk("c5_idle_busy", busy, 0);
    cyc();
    cmd_valid = 1'b0;
    chk("c5_second_accept_busy", busy, 1);
    chk("c5_second_mirror", mirror, 0);
    wait_done();
    chk_dither(4'd10, 1'b1);
    chk_dither(4'd9, 1'b0);

    // Case 6: reset in the middle of a seek.
    issue(4'd5, 2'd2, 4'b0010, 99, 1'b1);
    cyc();
    cmd_valid = 1'b0;
    chk("c6_mirror_first", mirror, 10);
    cyc();
    #2 rst = 1'b0;
    #1;
    chk("c6_rst_mirror", mirror, 0);
    chk("c6_rst_busy", busy, 0);
    chk("c6_rst_opt", opt, 0);
    chk("c6_rst_b", b, 0);
    chk("c6_rst_done", done, 0);
    chk("c6_rst_ready", cmd_ready, 0);
    void'(sb.pop_front());
    #1 rst = 1'b1;
    chk_dither(4'd1, 1'b1);
    chk_dither(4'd0, 1'b0);
    chk_dither(4'd1, 1'b1);

    // Case 3: from mirror=1 going down, tgt=14 -> 0,15,14.
    issue(4'd14, 2'd3, 4'b0001, 3, 1'b1);
    cyc();
    cmd_valid = 1'b0;
    chk("c3_mirror_first", mirror, 0);
    wait_done();
    chk_dither(4'd15, 1'b1);
    chk_dither(4'd14, 1'b0);

    // Case 4: tie, mirror_n=15 and tgt=7 (diff 8) -> counts up 0..7.
    issue(4'd7, 2'd0, 4'b1000, 9, 1'b0);
    cyc();
    cmd_valid = 1'b0;
    chk("c4_mirror_first", mirror, 15);
    wait_done();
    chk_dither(4'd8, 1'b1);
    chk_dither(4'd7, 1'b0);

    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
